div_clk_monitor: RTL and testbench

//  Consumer side of the divided-clock path. Takes the slow square wave produced by the

---
 rtl/div_clk_pkg.sv | 18 +
 rtl/sync_edge_det.sv | 43 ++++
 rtl/div_clk_monitor.sv | 134 +++++++++++++
 tb/tb_div_clk_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_clk_pkg.sv
// Types and default constants shared by the divided-clock path: the frequency divider and its monitor.
package div_clk_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2,
      LOST   = 2'd3
   } mon_state_t;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_EXPECTED_HALF = 50;
   localparam int DEF_TOL           = 2;
   localparam int DEF_LOCK_COUNT    = 4;
   localparam int DEF_TIMEOUT       = 128;
   localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_edge_det.sv
// Resynchronises an asynchronous level into CLK and flags its edges.
// edge_det is combinational, one cycle ahead of the registered rise/fall ticks.
module sync_edge_det
   import div_clk_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
)
(
   input  logic CLK,
   input  logic Reset,
   input  logic din,
   output logic edge_det,
   output logic rise_tick,
   output logic fall_tick
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   delay_reg;
   logic                   rise_reg;
   logic                   fall_reg;
   logic                   sync_last;

   assign sync_last = sync_reg[SYNC_STAGES-1];
   assign edge_det  = sync_last ^ delay_reg;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync_reg  <= '0;
         delay_reg <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din};
         delay_reg <= sync_last;
         rise_reg  <= sync_last & ~delay_reg;
         fall_reg  <= ~sync_last & delay_reg;
      end
   end

   assign rise_tick = rise_reg;
   assign fall_tick = fall_reg;

endmodule

// File: rtl/div_clk_monitor.sv
// Consumes the divided clock: emits clean rise/fall enables, measures each half-period
// and tracks lock against the expected divide ratio.
module div_clk_monitor
   import div_clk_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int EXPECTED_HALF = DEF_EXPECTED_HALF,
   parameter int TOL           = DEF_TOL,
   parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
   parameter int TIMEOUT       = DEF_TIMEOUT,
   parameter int CNT_W         = DEF_CNT_W
)
(
   input  logic             CLK,
   input  logic             Reset,
   input  logic             DivCLK_in,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic [CNT_W-1:0] half_period,
   output logic             period_valid,
   output logic             locked,
   output logic             lost,
   output logic [7:0]       err_count
);

   localparam int GR_W = $clog2(LOCK_COUNT + 1);
   localparam logic signed [CNT_W:0] EXP_S        = (CNT_W+1)'(EXPECTED_HALF);
   localparam logic [CNT_W:0]        TOL_V        = (CNT_W+1)'(TOL);
   localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [GR_W-1:0]       LOCK_V       = GR_W'(LOCK_COUNT);

   mon_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
   logic [GR_W-1:0]   good_run_reg, good_run_next, good_run_inc;
   logic [CNT_W-1:0]  half_period_reg, half_period_next;
   logic              period_valid_reg, period_valid_next;
   logic [7:0]        err_count_reg, err_count_next;
   logic              locked_reg, lost_reg;
   logic              edge_det;
   logic signed [CNT_W:0] diff_s;
   logic [CNT_W:0]    abs_diff;
   logic              in_tol;
   logic              timeout;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .CLK       (CLK),
      .Reset     (Reset),
      .din       (DivCLK_in),
      .edge_det  (edge_det),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   // cnt_inc doubles as the measured half-period on an edge cycle
   assign cnt_inc      = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
   assign diff_s       = $signed({1'b0, cnt_inc}) - EXP_S;
   assign abs_diff     = diff_s[CNT_W] ? $unsigned(-diff_s) : $unsigned(diff_s);
   assign in_tol       = (abs_diff <= TOL_V);
   assign timeout      = (cnt_reg == TIMEOUT_LAST);
   assign good_run_inc = good_run_reg + 1'b1;

   always_comb begin
      state_next        = state_reg;
      cnt_next          = cnt_inc;
      good_run_next     = good_run_reg;
      half_period_next  = half_period_reg;
      period_valid_next = 1'b0;
      err_count_next    = err_count_reg;
      if (edge_det) begin
         cnt_next = '0;
         case (state_reg)
            SEARCH, LOST: begin
               good_run_next = '0;
               state_next    = TRACK;
            end
            TRACK: begin
               half_period_next  = cnt_inc;
               period_valid_next = 1'b1;
               if (in_tol) begin
                  good_run_next = good_run_inc;
                  if (good_run_inc == LOCK_V)
                     state_next = LOCKED;
               end else begin
                  good_run_next = '0;
               end
            end
            LOCKED: begin
               half_period_next  = cnt_inc;
               period_valid_next = 1'b1;
               if (!in_tol) begin
                  state_next    = TRACK;
                  good_run_next = '0;
                  if (err_count_reg != 8'hFF)
                     err_count_next = err_count_reg + 8'd1;
               end
            end
         endcase
      end else if (timeout && state_reg != LOST) begin
         // an edge landing on the timeout cycle takes the branch above instead
         state_next = LOST;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_reg        <= SEARCH;
         cnt_reg          <= '0;
         good_run_reg     <= '0;
         half_period_reg  <= '0;
         period_valid_reg <= 1'b0;
         err_count_reg    <= '0;
         locked_reg       <= 1'b0;
         lost_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         cnt_reg          <= cnt_next;
         good_run_reg     <= good_run_next;
         half_period_reg  <= half_period_next;
         period_valid_reg <= period_valid_next;
         err_count_reg    <= err_count_next;
         locked_reg       <= (state_next == LOCKED);
         lost_reg         <= (state_next == LOST);
      end
   end

   assign half_period  = half_period_reg;
   assign period_valid = period_valid_reg;
   assign err_count    = err_count_reg;
   assign locked       = locked_reg;
   assign lost         = lost_reg;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: directed and random half-period sequences checked every cycle
// against an event-level model of tick timing, measurement and lock tracking.
module tb_div_clk_monitor;

   localparam int EXP_HALF   = 50;
   localparam int TOL        = 2;
   localparam int LOCK_COUNT = 4;
   localparam int TIMEOUT    = 128;
   localparam int LATENCY    = 3;

   localparam int M_SEARCH = 0;
   localparam int M_TRACK  = 1;
   localparam int M_LOCKED = 2;
   localparam int M_LOST   = 3;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic       DivCLK_in = 1'b0;
   logic       rise_tick, fall_tick, period_valid, locked, lost;
   logic [7:0] half_period;
   logic [7:0] err_count;

   div_clk_monitor dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .DivCLK_in    (DivCLK_in),
      .rise_tick    (rise_tick),
      .fall_tick    (fall_tick),
      .half_period  (half_period),
      .period_valid (period_valid),
      .locked       (locked),
      .lost         (lost),
      .err_count    (err_count)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int    n_assert = 0;
   int    n_fail   = 0;
   string phase    = "por";

   int   m_state, m_good, m_err, m_hp, m_last;
   logic m_level;
   logic e_rise, e_fall, e_pv;
   int   pending[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s @cyc %0d: observed %0d expected %0d", phase, tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      check("rise_tick",    32'(rise_tick),    32'(e_rise));
      check("fall_tick",    32'(fall_tick),    32'(e_fall));
      check("period_valid", 32'(period_valid), 32'(e_pv));
      check("half_period",  32'(half_period),  32'(m_hp));
      check("locked",       32'(locked),       32'(m_state == M_LOCKED));
      check("lost",         32'(lost),         32'(m_state == M_LOST));
      check("err_count",    32'(err_count),    32'(m_err));
   endtask

   task automatic model_reset();
      m_state = M_SEARCH;
      m_good  = 0;
      m_err   = 0;
      m_hp    = 0;
      m_level = 1'b0;
      m_last  = cyc;
      e_rise  = 1'b0;
      e_fall  = 1'b0;
      e_pv    = 1'b0;
      pending.delete();
   endtask

   // one CLK cycle: advance the model by one cycle, then compare all outputs
   task automatic step();
      int  meas;
      bit  tol_ok;
      @(posedge CLK);
      #1;
      e_rise = 1'b0;
      e_fall = 1'b0;
      e_pv   = 1'b0;
      if (!Reset) begin
         model_reset();
      end else if (pending.size() > 0 && pending[0] == cyc) begin
         void'(pending.pop_front());
         m_level = ~m_level;
         e_rise  = m_level;
         e_fall  = ~m_level;
         meas    = cyc - m_last;
         m_last  = cyc;
         tol_ok  = (meas >= EXP_HALF - TOL) && (meas <= EXP_HALF + TOL);
         case (m_state)
            M_SEARCH, M_LOST: begin
               m_state = M_TRACK;
               m_good  = 0;
            end
            M_TRACK: begin
               m_hp = meas;
               e_pv = 1'b1;
               if (tol_ok) begin
                  m_good++;
                  if (m_good == LOCK_COUNT) m_state = M_LOCKED;
               end else begin
                  m_good = 0;
               end
            end
            default: begin
               m_hp = meas;
               e_pv = 1'b1;
               if (!tol_ok) begin
                  m_state = M_TRACK;
                  m_good  = 0;
                  if (m_err < 255) m_err++;
               end
            end
         endcase
      end else if (cyc - m_last == TIMEOUT && m_state != M_LOST) begin
         m_state = M_LOST;
      end
      check_all();
   endtask

   task automatic toggle();
      DivCLK_in = ~DivCLK_in;
      pending.push_back(cyc + LATENCY);
   endtask

   task automatic run_half(input int n);
      toggle();
      repeat (n) step();
   endtask

   task automatic reset_pulse(input int hold, input logic level);
      Reset = 1'b0;
      #1;
      model_reset();
      check_all();
      DivCLK_in = level;
      repeat (hold) step();
      Reset = 1'b1;
      if (level) pending.push_back(cyc + LATENCY);
   endtask

   initial begin
      model_reset();
      #2;
      Reset = 1'b0;
      #1;
      check_all();
      repeat (3) step();
      Reset = 1'b1;

      phase = "lock50";
      repeat (7) run_half(EXP_HALF);

      phase = "err55";
      run_half(55);
      repeat (5) run_half(EXP_HALF);

      phase = "tol_edges";
      run_half(48);
      run_half(52);
      run_half(47);
      repeat (5) run_half(EXP_HALF);
      run_half(53);
      repeat (5) run_half(EXP_HALF);

      phase = "timeout";
      toggle();
      repeat (TIMEOUT + 20) step();
      repeat (6) run_half(EXP_HALF);

      phase = "edge_on_timeout";
      run_half(TIMEOUT);
      repeat (6) run_half(EXP_HALF);
      run_half(TIMEOUT + 1);
      repeat (6) run_half(EXP_HALF);

      phase = "random_near";
      repeat (60) run_half(int'($urandom_range(44, 56)));

      phase = "random_wide";
      repeat (20) run_half(int'($urandom_range(40, 135)));

      phase = "reset_mid";
      repeat (6) run_half(EXP_HALF);
      toggle();
      repeat (20) step();
      reset_pulse(2, 1'b1);
      repeat (10) step();
      repeat (6) run_half(EXP_HALF);
      reset_pulse(2, 1'b0);
      repeat (6) run_half(EXP_HALF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
